// File: rtl/interrupt_controller_pkg.sv
// Shared register map, FSM states and CLAIM word layout for the interrupt controller.
package interrupt_controller_pkg;

  localparam logic [2:0] ADDR_ENABLE  = 3'd0;
  localparam logic [2:0] ADDR_PENDING = 3'd1;
  localparam logic [2:0] ADDR_TRIGGER = 3'd2;
  localparam logic [2:0] ADDR_CLAIM   = 3'd3;
  localparam logic [2:0] ADDR_STATUS  = 3'd4;

  typedef enum logic {
    IDLE       = 1'b0,
    IN_SERVICE = 1'b1
  } state_e;

  typedef struct packed {
    logic        valid;
    logic [25:0] reserved;
    logic [4:0]  id;
  } claim_t;

  function automatic logic [31:0] strobe_mask(input logic [3:0] strobe);
    logic [31:0] mask;
    for (int b = 0; b < 4; b++) mask[b*8 +: 8] = {8{strobe[b]}};
    return mask;
  endfunction

endpackage

// File: rtl/interrupt_controller_priority_encoder.sv
// Fixed-priority arbiter: reports whether any request is set and the lowest set index.
module priority_encoder #(
  parameter int SOURCES = 8
) (
  input  logic [SOURCES-1:0] req_i,
  output logic               valid_o,
  output logic [4:0]         id_o
);

  always_comb begin
    valid_o = |req_i;
    id_o    = '0;
    // Scan downwards so the lowest index is the last one written.
    for (int i = SOURCES - 1; i >= 0; i--) begin
      if (req_i[i]) id_o = 5'(i);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Memory-mapped interrupt controller: per-source pending latches, fixed-priority
// arbitration and a claim/complete handshake towards the CPU.
//   state      | meaning
//   IDLE       | no interrupt in service; interrupt_o follows the arbitrated candidate
//   IN_SERVICE | one id claimed; interrupt_o held low until matching COMPLETE
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int SOURCES = 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [SOURCES-1:0] irq_i,
  input  logic               write_i,
  input  logic [31:0]        write_data_i,
  input  logic [2:0]         write_address_i,
  input  logic [3:0]         write_strobe_i,
  output logic               write_error_o,
  input  logic               read_i,
  input  logic [2:0]         read_address_i,
  output logic [31:0]        read_data_o,
  output logic               read_error_o,
  output logic               interrupt_o
);

  logic [SOURCES-1:0] enable_q, enable_d;
  logic [SOURCES-1:0] pending_q, pending_d;
  logic [SOURCES-1:0] trigger_q, trigger_d;
  logic [SOURCES-1:0] prev_irq_q;
  logic [SOURCES-1:0] candidate, rise, w1c, claim_clr, wmask, wdata;
  state_e             state_q, state_d;
  logic [4:0]         in_service_id_q, in_service_id_d;
  logic               interrupt_q, interrupt_d;
  logic               win_valid;
  logic [4:0]         win_id;
  logic               claim_fire, id_match;
  logic [31:0]        mask32;
  claim_t             claim_rd;
  logic               unused_bits;

  assign mask32      = strobe_mask(write_strobe_i);
  assign wmask       = mask32[SOURCES-1:0];
  assign wdata       = write_data_i[SOURCES-1:0];
  assign unused_bits = ^{write_data_i, mask32};

  assign candidate = pending_q & enable_q;
  assign rise      = irq_i & ~prev_irq_q;

  priority_encoder #(.SOURCES(SOURCES)) u_prio (
    .req_i  (candidate),
    .valid_o(win_valid),
    .id_o   (win_id)
  );

  assign id_match   = (state_q == IN_SERVICE) && (write_data_i[4:0] == in_service_id_q);
  assign claim_fire = read_i && (read_address_i == ADDR_CLAIM) && (state_q == IDLE) && win_valid;

  assign write_error_o = write_i && ((write_address_i >= ADDR_STATUS) ||
                                     ((write_address_i == ADDR_CLAIM) && !id_match));
  assign read_error_o  = read_i && (read_address_i > ADDR_STATUS);

  always_comb begin
    enable_d  = enable_q;
    trigger_d = trigger_q;
    w1c       = '0;
    claim_clr = '0;
    pending_d = '0;
    if (write_i && write_address_i == ADDR_ENABLE)  enable_d  = (enable_q & ~wmask) | (wdata & wmask);
    if (write_i && write_address_i == ADDR_TRIGGER) trigger_d = (trigger_q & ~wmask) | (wdata & wmask);
    if (write_i && write_address_i == ADDR_PENDING) w1c       = wdata & wmask;
    // Edge sources: a new edge beats a same-cycle clear. Level sources track the line.
    for (int i = 0; i < SOURCES; i++) begin
      claim_clr[i] = claim_fire && (win_id == 5'(i));
      pending_d[i] = trigger_q[i] ? ((pending_q[i] & ~(w1c[i] | claim_clr[i])) | rise[i])
                                  : irq_i[i];
    end
  end

  always_comb begin
    state_d         = state_q;
    in_service_id_d = in_service_id_q;
    interrupt_d     = 1'b0;
    case (state_q)
      IDLE: begin
        interrupt_d = win_valid && !claim_fire;
        if (claim_fire) begin
          state_d         = IN_SERVICE;
          in_service_id_d = win_id;
        end
      end
      IN_SERVICE: begin
        if (write_i && write_address_i == ADDR_CLAIM && id_match) state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    claim_rd    = '0;
    read_data_o = '0;
    if (state_q == IDLE && win_valid) begin
      claim_rd.valid = 1'b1;
      claim_rd.id    = win_id;
    end
    case (read_address_i)
      ADDR_ENABLE:  read_data_o = 32'(enable_q);
      ADDR_PENDING: read_data_o = 32'(pending_q);
      ADDR_TRIGGER: read_data_o = 32'(trigger_q);
      ADDR_CLAIM:   read_data_o = claim_rd;
      ADDR_STATUS:  read_data_o = {state_q == IN_SERVICE, 26'd0, in_service_id_q};
      default:      read_data_o = '0;
    endcase
    if (read_error_o) read_data_o = '0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      enable_q        <= '0;
      pending_q       <= '0;
      trigger_q       <= '1;
      prev_irq_q      <= '0;
      state_q         <= IDLE;
      in_service_id_q <= '0;
      interrupt_q     <= 1'b0;
    end else begin
      enable_q        <= enable_d;
      pending_q       <= pending_d;
      trigger_q       <= trigger_d;
      prev_irq_q      <= irq_i;
      state_q         <= state_d;
      in_service_id_q <= in_service_id_d;
      interrupt_q     <= interrupt_d;
    end
  end

  assign interrupt_o = interrupt_q;

endmodule
